pipe_ctrl_scoreboard: RTL and testbench

Decode-stage control and hazard unit for the 5-stage pipelined processor.
- Decodes opcode/ALU_op/rd/rs/rt into regfile read/write selects and the register write enable.
- Tracks in-flight register writes in a parametrised-depth scoreboard.
- Raises stall for load-use hazards and for the multicycle mul/div unit.
- Produces per-operand forwarding selects.
- Sits between fetch/decode latch and the D/X pipeline register.

---
 rtl/pipe_ctrl_scoreboard.sv | 176 +++++++++++++++++
 tb/tb_pipe_ctrl_scoreboard.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_scoreboard.sv
// Decode-stage control and hazard unit: register selects, in-flight write scoreboard,
// load-use / mul-div stall and per-operand forwarding selects.
module pipe_ctrl_scoreboard #(
    parameter int REG_W         = 5,
    parameter int PIPE_DEPTH    = 3,
    parameter int MULDIV_CYCLES = 32,
    parameter int STATUS_REG    = 30,
    parameter int RA_REG        = 31
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       opcode,
    input  logic [4:0]       alu_op,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic [REG_W-1:0] ctrl_readRegA,
    output logic [REG_W-1:0] ctrl_readRegB,
    output logic [REG_W-1:0] ctrl_writeReg,
    output logic             rwe,
    output logic             stall,
    output logic             issue,
    output logic [2:0]       fwd_selA,
    output logic [2:0]       fwd_selB,
    output logic             muldiv_busy
);
    localparam int CNT_W = $clog2(MULDIV_CYCLES);
    localparam logic [REG_W-1:0] STAT_R = REG_W'(STATUS_REG);
    localparam logic [REG_W-1:0] RA_R   = REG_W'(RA_REG);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    logic [REG_W-1:0] w_selA, w_selB, w_dst;
    logic             w_wr, w_ld, w_sp, w_md, w_rwe;

    always_comb begin
        w_selA = '0;
        w_selB = '0;
        w_dst  = '0;
        w_wr   = 1'b0;
        w_ld   = 1'b0;
        w_sp   = 1'b0;
        w_md   = 1'b0;
        case (opcode) inside
            OP_R: begin
                w_selA = rs;
                w_selB = rt;
                w_dst  = rd;
                w_wr   = 1'b1;
                w_sp   = alu_op inside {5'b00000, 5'b00001, 5'b00110, 5'b00111};
                w_md   = alu_op inside {5'b00110, 5'b00111};
            end
            OP_ADDI: begin
                w_selA = rs;
                w_dst  = rd;
                w_wr   = 1'b1;
                w_sp   = 1'b1;
            end
            OP_LW: begin
                w_selA = rs;
                w_dst  = rd;
                w_wr   = 1'b1;
                w_ld   = 1'b1;
            end
            [5'b01001:5'b01111]: begin
                w_selA = rs;
                w_selB = rt;
                w_dst  = rd;
                w_wr   = 1'b1;
            end
            OP_SW: begin
                w_selA = rs;
                w_selB = rd;
            end
            OP_BNE, OP_BLT: begin
                w_selA = rd;
                w_selB = rs;
            end
            OP_JR:   w_selA = rd;
            OP_JAL: begin
                w_dst = RA_R;
                w_wr  = 1'b1;
            end
            OP_SETX: begin
                w_dst = STAT_R;
                w_wr  = 1'b1;
            end
            OP_BEX:  w_selA = STAT_R;
            default: ;
        endcase
    end

    assign w_rwe = in_valid & w_wr & (w_dst != '0);

    logic [PIPE_DEPTH:1]            r_vld_pipe, r_ld, r_sp;
    logic [PIPE_DEPTH:1][REG_W-1:0] r_dst;
    logic [CNT_W-1:0]               r_cnt;

    // A zero select is an unused operand, so it can never hit; non-writers store dest 0.
    logic [PIPE_DEPTH:1] w_hitA, w_hitB, w_candA, w_candB;
    always_comb begin
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
            w_hitA[k] = r_vld_pipe[k] & (w_selA != '0) &
                        ((r_dst[k] == w_selA) | (r_sp[k] & (w_selA == STAT_R)));
            w_hitB[k] = r_vld_pipe[k] & (w_selB != '0) &
                        ((r_dst[k] == w_selB) | (r_sp[k] & (w_selB == STAT_R)));
        end
        w_candA    = w_hitA;
        w_candB    = w_hitB;
        w_candA[1] = w_hitA[1] & ~r_ld[1];
        w_candB[1] = w_hitB[1] & ~r_ld[1];
    end

    logic       w_load_use;
    logic [2:0] w_fwdA, w_fwdB;
    assign w_load_use = r_ld[1] & (w_hitA[1] | w_hitB[1]);

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        w_fwdA = '0;
        w_fwdB = '0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (w_candA[k]) w_fwdA = 3'(k);
            if (w_candB[k]) w_fwdB = 3'(k);
        end
    end

    assign muldiv_busy   = (r_cnt != '0);
    assign stall         = in_valid & (muldiv_busy | w_load_use);
    assign issue         = in_valid & ~stall;
    assign ctrl_readRegA = w_selA;
    assign ctrl_readRegB = w_selB;
    assign ctrl_writeReg = w_dst;
    assign rwe           = w_rwe;
    assign fwd_selA      = w_fwdA;
    assign fwd_selB      = w_fwdB;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_dst      <= '0;
            r_ld       <= '0;
            r_sp       <= '0;
        end else begin
            r_vld_pipe[1] <= issue;
            r_dst[1]      <= w_rwe ? w_dst : '0;
            r_ld[1]       <= w_ld;
            r_sp[1]       <= w_sp;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_dst[k]      <= r_dst[k-1];
                r_ld[k]       <= r_ld[k-1];
                r_sp[k]       <= r_sp[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_cnt <= '0;
        else if (issue & w_md)
            r_cnt <= CNT_W'(MULDIV_CYCLES - 1);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_ctrl_scoreboard.sv
// Directed scoreboard bench: expected outputs queued at drive time, compared on the falling edge.
module tb_pipe_ctrl_scoreboard;
    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] opcode = '0, alu_op = '0, rd = '0, rs = '0, rt = '0;
    logic [4:0] ra, rb, wr, ra5, rb5, wr5;
    logic       rwe, stall, issue, busy, rwe5, stall5, issue5, busy5;
    logic [2:0] fa, fb, fa5, fb5;

    always #5 clock = ~clock;

    pipe_ctrl_scoreboard dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .opcode(opcode), .alu_op(alu_op),
        .rd(rd), .rs(rs), .rt(rt), .ctrl_readRegA(ra), .ctrl_readRegB(rb), .ctrl_writeReg(wr),
        .rwe(rwe), .stall(stall), .issue(issue), .fwd_selA(fa), .fwd_selB(fb), .muldiv_busy(busy)
    );

    pipe_ctrl_scoreboard #(.PIPE_DEPTH(5)) dut5 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .opcode(opcode), .alu_op(alu_op),
        .rd(rd), .rs(rs), .rt(rt), .ctrl_readRegA(ra5), .ctrl_readRegB(rb5), .ctrl_writeReg(wr5),
        .rwe(rwe5), .stall(stall5), .issue(issue5), .fwd_selA(fa5), .fwd_selB(fb5), .muldiv_busy(busy5)
    );

    typedef struct {
        string      tag;
        logic       stall, issue, busy, rwe;
        logic [2:0] fa, fb;
        logic [4:0] ra, rb, wr;
        int         fa5;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check_eq({mon_e.tag, ".stall"}, stall, mon_e.stall);
            check_eq({mon_e.tag, ".issue"}, issue, mon_e.issue);
            check_eq({mon_e.tag, ".busy"},  busy,  mon_e.busy);
            check_eq({mon_e.tag, ".fwdA"},  fa,    mon_e.fa);
            check_eq({mon_e.tag, ".fwdB"},  fb,    mon_e.fb);
            check_eq({mon_e.tag, ".readA"}, ra,    mon_e.ra);
            check_eq({mon_e.tag, ".readB"}, rb,    mon_e.rb);
            check_eq({mon_e.tag, ".write"}, wr,    mon_e.wr);
            check_eq({mon_e.tag, ".rwe"},   rwe,   mon_e.rwe);
            if (mon_e.fa5 >= 0) check_eq({mon_e.tag, ".fwdA5"}, fa5, mon_e.fa5);
        end
    end

    // Opcode table: expected read/write selects straight from the ISA field usage.
    task automatic expect_decode(input logic v, input logic [4:0] op, input logic [4:0] d,
                                 input logic [4:0] s, input logic [4:0] t, inout exp_t e);
        logic w;
        e.ra = 0; e.rb = 0; e.wr = 0; w = 0;
        case (op)
            5'd0, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin e.ra = s; e.rb = t; e.wr = d; w = 1; end
            5'd5, 5'd8: begin e.ra = s; e.wr = d; w = 1; end
            5'd7:       begin e.ra = s; e.rb = d; end
            5'd2, 5'd6: begin e.ra = d; e.rb = s; end
            5'd4:       e.ra = d;
            5'd3:       begin e.wr = 5'd31; w = 1; end
            5'd21:      begin e.wr = 5'd30; w = 1; end
            5'd22:      e.ra = 5'd30;
            default: ;
        endcase
        e.rwe = v & w & (e.wr != 0);
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] op, input logic [4:0] alu,
                        input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                        input logic est, input logic ebusy, input logic [2:0] efa,
                        input logic [2:0] efb, input int efa5 = -1);
        exp_t e;
        @(posedge clock);
        #1;
        reset = 1'b0; in_valid = v; opcode = op; alu_op = alu; rd = d; rs = s; rt = t;
        e.tag = tag; e.stall = est; e.issue = v & ~est; e.busy = ebusy;
        e.fa = efa; e.fb = efb; e.fa5 = efa5;
        expect_decode(v, op, d, s, t, e);
        q.push_back(e);
    endtask

    task automatic bub(input int n);
        repeat (n) step("bubble", 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        // reset state
        step("rst",     1, OP_R, 5'd0, 5'd1, 5'd2, 5'd3, 0, 0, 3'd0, 3'd0, 0);
        bub(3);
        // load-use: one stall, then forward from stage 2
        step("lw",      1, OP_LW, 5'd0, 5'd5, 5'd1, 5'd0, 0, 0, 3'd0, 3'd0);
        step("lu_stl",  1, OP_R,  5'd0, 5'd6, 5'd5, 5'd2, 1, 0, 3'd0, 3'd0);
        step("lu_go",   1, OP_R,  5'd0, 5'd6, 5'd5, 5'd2, 0, 0, 3'd2, 3'd0);
        bub(3);
        // back-to-back and one-bubble forwarding
        step("add3",    1, OP_R, 5'd0, 5'd3, 5'd1, 5'd2, 0, 0, 3'd0, 3'd0);
        step("sub_b2b", 1, OP_R, 5'd1, 5'd4, 5'd3, 5'd3, 0, 0, 3'd1, 3'd1, 1);
        bub(3);
        step("add3b",   1, OP_R, 5'd0, 5'd3, 5'd1, 5'd2, 0, 0, 3'd0, 3'd0);
        bub(1);
        step("sub_gap", 1, OP_R, 5'd1, 5'd4, 5'd3, 5'd3, 0, 0, 3'd2, 3'd2);
        bub(3);
        // status / return-address / store decoding
        step("setx",    1, OP_SETX, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 3'd0, 3'd0);
        step("bex",     1, OP_BEX,  5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 3'd1, 3'd0);
        step("jal",     1, OP_JAL,  5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 3'd0, 3'd0);
        step("sw",      1, OP_SW,   5'd0, 5'd4, 5'd2, 5'd0, 0, 0, 3'd0, 3'd0);
        step("add_st",  1, OP_R,    5'd0, 5'd3, 5'd1, 5'd2, 0, 0, 3'd0, 3'd0);
        step("bex_sh",  1, OP_BEX,  5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 3'd1, 3'd0);
        bub(3);
        // register 0 is never written or hazard-matched
        step("addi_r0", 1, OP_ADDI, 5'd0, 5'd0, 5'd1, 5'd0, 0, 0, 3'd0, 3'd0);
        step("add_r0",  1, OP_R,    5'd0, 5'd8, 5'd0, 5'd0, 0, 0, 3'd0, 3'd0);
        step("lw_r0",   1, OP_LW,   5'd0, 5'd0, 5'd1, 5'd0, 0, 0, 3'd0, 3'd0);
        step("use_r0",  1, OP_R,    5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 3'd0, 3'd0);
        bub(5);
        // deep scoreboard: stage-5 forward, then aged out
        step("add9",    1, OP_R, 5'd0, 5'd9,  5'd1, 5'd2, 0, 0, 3'd0, 3'd0, 0);
        bub(4);
        step("rd9_d5",  1, OP_R, 5'd0, 5'd10, 5'd9, 5'd0, 0, 0, 3'd0, 3'd0, 5);
        step("add9b",   1, OP_R, 5'd0, 5'd9,  5'd1, 5'd2, 0, 0, 3'd0, 3'd0, 0);
        bub(5);
        step("rd9_old", 1, OP_R, 5'd0, 5'd11, 5'd9, 5'd0, 0, 0, 3'd0, 3'd0, 0);
        bub(3);
        // mul occupancy: 31 stalled cycles, bubble in the middle never stalls
        step("mul",     1, OP_R, 5'd6, 5'd7, 5'd1, 5'd2, 0, 0, 3'd0, 3'd0);
        for (int i = 1; i <= 31; i++) begin
            if (i == 15) step("mul_bub", 0, OP_R, 5'd0, 5'd8, 5'd1, 5'd2, 0, 1, 3'd0, 3'd0);
            else         step("mul_stl", 1, OP_R, 5'd0, 5'd8, 5'd1, 5'd2, 1, 1, 3'd0, 3'd0);
        end
        step("mul_done", 1, OP_R, 5'd0, 5'd8, 5'd1, 5'd2, 0, 0, 3'd0, 3'd0);
        // div aborted by reset mid-count
        step("div",     1, OP_R, 5'd7, 5'd7, 5'd1, 5'd2, 0, 0, 3'd0, 3'd0);
        for (int i = 1; i <= 9; i++)
            step("div_stl", 1, OP_R, 5'd0, 5'd8, 5'd1, 5'd2, 1, 1, 3'd0, 3'd0);
        @(posedge clock);
        #1;
        reset = 1'b1; in_valid = 1'b0;
        step("post_rst", 1, OP_R, 5'd0, 5'd8, 5'd7, 5'd1, 0, 0, 3'd0, 3'd0, 0);
        @(negedge clock);
        #1;
        check_eq("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
